// File: rtl/bram_stream_reader.sv
// bram_stream_reader
// Read-side initiator for a single-port BRAM with a registered read
// (1-cycle latency). A start command streams `len` consecutive words
// from `start_addr`, wrapping modulo 2**ADDR_WIDTH, out of a valid/ready
// interface. A 4-entry FIFO absorbs the read latency and backpressure.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, start_addr,
//   len                 command (accepted only while idle)
//   busy, done          status; done is a single-cycle completion pulse
//   bram_addr,
//   bram_write_en,
//   bram_data_in,
//   bram_data_out       BRAM side (write port tied off)
//   out_valid, out_data,
//   out_last, out_ready stream side
//   stall_cnt           only with BRAM_READER_STALL_CNT_EN defined:
//                       saturating count of out_valid & !out_ready cycles
//
// Optional feature macro: BRAM_READER_STALL_CNT_EN
//
// state | meaning
// IDLE  | waiting for start
// ZERO  | zero-length command, done pulse
// ISSUE | reads being issued
// DRAIN | all reads issued, waiting for the last word to leave
module bram_stream_reader #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [LEN_WIDTH-1:0]  len,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic                  bram_write_en,
  output logic [DATA_WIDTH-1:0] bram_data_in,
  input  logic [DATA_WIDTH-1:0] bram_data_out,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  input  logic                  out_ready
`ifdef BRAM_READER_STALL_CNT_EN
  ,
  output logic [15:0]           stall_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, ZERO, ISSUE, DRAIN} state_t;

  state_t                state, state_nx;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  issue_left;
  logic [LEN_WIDTH-1:0]  out_left;
  logic                  inflight;
  logic                  done_q;
  logic [DATA_WIDTH-1:0] fifo_mem [4];
  logic [1:0]            wr_ptr, rd_ptr;
  logic [2:0]            fifo_count;
  logic                  start_acc, can_issue, issue, push, pop, last_pop;

  // Count the word still in the BRAM pipeline so a full FIFO can never
  // be overrun by the read that lands next cycle.
  assign can_issue = (({1'b0, fifo_count} + {3'b000, inflight}) <= 4'd2);
  assign push      = inflight;
  assign pop       = out_valid && out_ready;
  assign last_pop  = pop && (out_left == LEN_WIDTH'(1)) && (state == DRAIN);

  assign out_valid     = (fifo_count != 3'd0);
  assign out_data      = fifo_mem[rd_ptr];
  assign out_last      = out_valid && (out_left == LEN_WIDTH'(1));
  assign busy          = (state != IDLE);
  assign done          = done_q || (state == ZERO);
  assign bram_addr     = addr_q;
  assign bram_write_en = 1'b0;
  assign bram_data_in  = '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    start_acc = 1'b0;
    issue     = 1'b0;
    case (state)
      IDLE: begin
        // The completion-pulse cycle is still part of the old transfer.
        if (start && !done_q) begin
          start_acc = 1'b1;
          state_nx  = (len != '0) ? ISSUE : ZERO;
        end
      end
      ZERO: state_nx = IDLE;
      ISSUE: begin
        if (can_issue) begin
          issue = 1'b1;
          if (issue_left == LEN_WIDTH'(1)) state_nx = DRAIN;
        end
      end
      DRAIN: begin
        if (last_pop) state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= '0;
      issue_left <= '0;
      out_left   <= '0;
      inflight   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      inflight <= issue;
      done_q   <= last_pop;
      if (start_acc) begin
        addr_q     <= start_addr;
        issue_left <= len;
        out_left   <= len;
      end else begin
        if (issue) begin
          addr_q     <= addr_q + 1'b1;
          issue_left <= issue_left - 1'b1;
        end
        if (pop) out_left <= out_left - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) fifo_mem[i] <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= bram_data_out;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

`ifdef BRAM_READER_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (start_acc) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_bram_stream_reader.sv
module tb_bram_stream_reader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] start_addr;
  logic [4:0] len;
  logic       busy, done;
  logic [3:0] bram_addr;
  logic       bram_write_en;
  logic [7:0] bram_data_in;
  logic [7:0] bram_data_out;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_last;
  logic       out_ready;
`ifdef BRAM_READER_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int tests = 0;
  int fails = 0;

  logic [7:0] mem [16];
  logic [7:0] got_data [$];
  logic       got_last [$];
  int         done_cnt;
  int         we_bad;
  int         max_out;
  logic [3:0] cur_start;
  logic [3:0] mon_d;

  always #5 clk = ~clk;

  bram_stream_reader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr), .len(len),
    .busy(busy), .done(done), .bram_addr(bram_addr), .bram_write_en(bram_write_en),
    .bram_data_in(bram_data_in), .bram_data_out(bram_data_out),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready)
`ifdef BRAM_READER_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  // BRAM: registered read, one cycle of latency.
  always @(posedge clk) bram_data_out <= mem[bram_addr];

  always @(negedge clk) begin
    if (bram_write_en !== 1'b0) we_bad++;
    if (rst_n) begin
      if (busy) begin
        mon_d = bram_addr - cur_start;
        if (int'(mon_d) - got_data.size() > max_out) max_out = int'(mon_d) - got_data.size();
      end
      if (out_valid && out_ready) begin
        got_data.push_back(out_data);
        got_last.push_back(out_last);
      end
      if (done) done_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    got_data.delete();
    got_last.delete();
    done_cnt = 0;
    max_out  = 0;
  endtask

  task automatic wait_done(input string tag, input int budget, input bit rand_ready);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    chk({tag, "_done_seen"}, done, 1'b1);
    out_ready = 1'b1;
  endtask

  task automatic go(input logic [3:0] a, input logic [4:0] l);
    start_addr = a;
    len        = l;
    cur_start  = a;
    start      = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'(3 * i);
    rst_n = 1'b0; start = 1'b0; start_addr = '0; len = '0; out_ready = 1'b1;
    cur_start = '0; we_bad = 0;
    clear_mon();
    tick(); tick();
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_addr", bram_addr, 4'd0);
    chk("rst_last", out_last, 1'b0);
    rst_n = 1'b1;
    tick();

    // Basic: start_addr=2, len=4
    clear_mon();
    go(4'd2, 5'd4);                           // cycle k+1
    chk("basic_addr_k1", bram_addr, 4'd2);
    chk("basic_busy_k1", busy, 1'b1);
    chk("basic_valid_k1", out_valid, 1'b0);
    tick();                                   // k+2
    chk("basic_addr_k2", bram_addr, 4'd3);
    chk("basic_valid_k2", out_valid, 1'b0);
    tick();                                   // k+3
    chk("basic_addr_k3", bram_addr, 4'd4);
    chk("basic_valid_k3", out_valid, 1'b1);
    chk("basic_data_k3", out_data, 8'd6);
    chk("basic_last_k3", out_last, 1'b0);
    tick();                                   // k+4
    chk("basic_addr_k4", bram_addr, 4'd5);
    chk("basic_data_k4", out_data, 8'd9);
    tick();                                   // k+5
    chk("basic_data_k5", out_data, 8'd12);
    chk("basic_last_k5", out_last, 1'b0);
    tick();                                   // k+6
    chk("basic_data_k6", out_data, 8'd15);
    chk("basic_last_k6", out_last, 1'b1);
    chk("basic_done_k6", done, 1'b0);
    tick();                                   // k+7
    chk("basic_done_k7", done, 1'b1);
    chk("basic_busy_k7", busy, 1'b0);
    chk("basic_valid_k7", out_valid, 1'b0);
    tick();
    chk("basic_done_k8", done, 1'b0);
    chk("basic_count", got_data.size(), 4);
    chk("basic_done_cnt", done_cnt, 1);

    // Wrap: start_addr=14, len=4
    clear_mon();
    go(4'd14, 5'd4);
    chk("wrap_addr_k1", bram_addr, 4'd14);
    tick();
    chk("wrap_addr_k2", bram_addr, 4'd15);
    tick();
    chk("wrap_addr_k3", bram_addr, 4'd0);
    tick();
    chk("wrap_addr_k4", bram_addr, 4'd1);
    wait_done("wrap", 20, 1'b0);
    tick();
    chk("wrap_count", got_data.size(), 4);
    chk("wrap_d0", got_data[0], 8'd42);
    chk("wrap_d1", got_data[1], 8'd45);
    chk("wrap_d2", got_data[2], 8'd0);
    chk("wrap_d3", got_data[3], 8'd3);
    chk("wrap_last3", got_last[3], 1'b1);

    // Backpressure: len=8, out_ready low for k+3..k+7
    clear_mon();
    go(4'd0, 5'd8);                           // k+1
    tick();                                   // k+2
    tick();                                   // k+3
    out_ready = 1'b0;
    tick(); tick(); tick();                   // k+6
    chk("bp_addr_stall", bram_addr, 4'd3);
    chk("bp_valid_held", out_valid, 1'b1);
    chk("bp_data_held", out_data, 8'd0);
    tick();                                   // k+7
    chk("bp_data_held_k7", out_data, 8'd0);
    tick();                                   // k+8
    out_ready = 1'b1;
    wait_done("bp", 40, 1'b0);
`ifdef BRAM_READER_STALL_CNT_EN
    chk("bp_stall_cnt", stall_cnt, 16'd5);
`endif
    tick();
    chk("bp_count", got_data.size(), 8);
    chk("bp_max_outstanding", max_out, 3);
    for (int i = 0; i < 8; i++) begin
      if (i < got_data.size()) begin
        chk($sformatf("bp_d%0d", i), got_data[i], 8'(3 * i));
        chk($sformatf("bp_last%0d", i), got_last[i], (i == 7) ? 1'b1 : 1'b0);
      end
    end
`ifdef BRAM_READER_STALL_CNT_EN
    chk("bp_stall_cnt_hold", stall_cnt, 16'd5);
`endif

    // Zero-length command
    clear_mon();
    go(4'd7, 5'd0);                           // k+1
    chk("zero_done_k1", done, 1'b1);
    tick();
    chk("zero_done_k2", done, 1'b0);
    chk("zero_busy_k2", busy, 1'b0);
    tick(); tick(); tick();
    chk("zero_no_words", got_data.size(), 0);
    chk("zero_done_cnt", done_cnt, 1);

    // Start while busy is ignored
    clear_mon();
    go(4'd0, 5'd4);
    tick();
    start_addr = 4'd8; len = 5'd2; start = 1'b1;
    tick(); tick();
    start = 1'b0;
    wait_done("ign", 20, 1'b0);
    tick(); tick(); tick();
    chk("ign_count", got_data.size(), 4);
    chk("ign_busy_after", busy, 1'b0);
    chk("ign_done_cnt", done_cnt, 1);
    for (int i = 0; i < 4; i++)
      if (i < got_data.size()) chk($sformatf("ign_d%0d", i), got_data[i], 8'(3 * i));

    // Full memory, random backpressure
    clear_mon();
    go(4'd5, 5'd16);
    wait_done("full", 400, 1'b1);
    tick(); tick();
    chk("full_count", got_data.size(), 16);
    chk("full_done_cnt", done_cnt, 1);
    for (int i = 0; i < 16; i++) begin
      if (i < got_data.size()) begin
        chk($sformatf("full_d%0d", i), got_data[i], 8'(3 * ((5 + i) % 16)));
        chk($sformatf("full_last%0d", i), got_last[i], (i == 15) ? 1'b1 : 1'b0);
      end
    end

    // Reset mid-stream
    clear_mon();
    go(4'd3, 5'd8);
    tick(); tick(); tick();
    chk("mid_valid_before", out_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_done", done, 1'b0);
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_addr", bram_addr, 4'd0);
    chk("mid_rst_we", bram_write_en, 1'b0);
    tick(); tick();
    rst_n = 1'b1;
    done_cnt = 0;
    repeat (20) tick();
    chk("mid_no_done", done_cnt, 0);
    chk("mid_idle_valid", out_valid, 1'b0);
    chk("we_never_set", we_bad, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bram_stream_reader.md
Name: bram_stream_reader

Overview:
- Read-side initiator for the single-port BRAM primitive (registered read, 1-cycle latency, write-first not relied upon).
- On a start command, streams `len` consecutive words from `start_addr` out a valid/ready interface, with wrap-around addressing.
- Absorbs the BRAM read latency and downstream backpressure with an internal 4-entry FIFO.
- Sits between a BRAM instance and any streaming consumer (e.g. a tile loader feeding the alignment arrays).

Parameters:
ADDR_WIDTH, 4, BRAM address width; memory depth is 2**ADDR_WIDTH words
DATA_WIDTH, 8, BRAM word width
LEN_WIDTH, ADDR_WIDTH+1, width of transfer length; allows a full-memory read

Ports:
clk  input  1  sole clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  command strobe; accepted only when busy=0
start_addr  input  ADDR_WIDTH  first word address
len  input  LEN_WIDTH  number of words to read (0 allowed)
busy  output  1  transfer in progress
done  output  1  single-cycle pulse at transfer completion
bram_addr  output  ADDR_WIDTH  to BRAM addr
bram_write_en  output  1  to BRAM write_en; constant 0
bram_data_in  output  DATA_WIDTH  to BRAM data_in; constant 0
bram_data_out  input  DATA_WIDTH  from BRAM data_out
out_valid  output  1  stream word valid
out_data  output  DATA_WIDTH  stream word
out_last  output  1  marks final word; qualified by out_valid
out_ready  input  1  consumer ready

Behaviour:
- Reset: all outputs 0; FIFO emptied; state IDLE; in-flight read discarded. Reset mid-transfer aborts silently, with no done pulse.
- States:
  - IDLE: start=1 latches start_addr/len. Next state is ISSUE if len>0, else ZERO.
  - ZERO: done=1 for one cycle, then IDLE.
  - ISSUE: issues reads.
  - DRAIN: all reads issued; waits for FIFO empty.
- busy=1 in every state except IDLE. start while busy=1 is ignored.
- Read issue:
  - A read issues in a cycle only when fifo_count + inflight <= 2. inflight is 0/1, set by an issue and cleared the following cycle when bram_data_out is pushed into the FIFO.
  - bram_addr is registered. The first address is presented in the cycle after start is accepted.
  - Each issue increments bram_addr modulo 2**ADDR_WIDTH (wraps 2**ADDR_WIDTH-1 -> 0) and decrements the remaining count.
  - The last issue moves the state to DRAIN.
- Latency: start sampled at edge k. start_addr is on bram_addr during cycle k+1, data is on bram_data_out in cycle k+2, and out_valid=1 in cycle k+3.
- Throughput: with out_ready held at 1, one word per cycle, no bubbles.
- FIFO:
  - Depth 4. out_data/out_valid are driven from the FIFO head.
  - Push and pop in the same cycle leave the count unchanged.
  - The FIFO never overflows; the issue rule guarantees this.
  - out_data holds stable while out_valid=1 and out_ready=0.
- out_last=1 on the word whose handshake completes the len-th word.
- done pulses in the cycle after that handshake. busy falls in the same cycle done pulses.
- A new start is accepted in the cycle after done.
- len=2**ADDR_WIDTH reads every word exactly once.

Optional Feature:
BRAM_READER_STALL_CNT_EN
- Defined:
  - Adds output port stall_cnt [15:0].
  - Counts cycles with out_valid=1 and out_ready=0, saturating at 16'hFFFF.
  - Cleared to 0 on an accepted start, and by reset.
  - Holds its value after done until the next start.
- Undefined: the port and the counter logic are absent; all other behaviour is identical.

Test Plan:
- Reset: assert rst_n=0 mid-stream -> busy, done, out_valid, bram_write_en, bram_addr all 0 immediately. After release, no done pulse occurs; bram_write_en stays 0 always.
- Basic: preload mem[i]=3*i; start_addr=2, len=4, out_ready=1, start at edge k -> bram_addr 2,3,4,5 in cycles k+1..k+4; out_data 6,9,12,15 in cycles k+3..k+6; out_last only with 15; done pulse in k+7.
- Wrap: ADDR_WIDTH=4, start_addr=14, len=4 -> bram_addr 14,15,0,1; out_data = mem[14],mem[15],mem[0],mem[1].
- Backpressure: len=8, out_ready=0 for cycles k+3..k+7, then 1 -> bram_addr stalls with at most 3 words issued-not-consumed; all 8 words delivered in order with no loss or duplication; stall_cnt=5 when the macro is defined.
- Zero/ignore: len=0 -> done pulse in cycle k+1, out_valid never 1. A start asserted while busy=1 during a len=4 transfer is ignored; only 4 words are produced.
- Full memory: len=16, out_ready random at 50% -> 16 words mem[a..a+15 mod 16] in order; exactly one done pulse.
